// File: rtl/fir_acc_pkg.sv
// ---------------------------------------------------------------------------
// fir_acc_pkg
//   Shared widths, constants, state type and helpers for the FIR MAC
//   accumulator stage (fir_mac_accumulator + fir_round_sat).
//
//   PROD_W     : signed product width coming from the 16s x 12ns multiplier
//   MAX_TAPS   : maximum number of products summed into one output sample
//   TAP_CNT_W  : tap counter width, also the accumulator guard-bit count
//   ACC_W      : accumulator width, wide enough for MAX_TAPS full-scale
//                products so the sum can never wrap
//   FRAC_SHIFT : coefficient fraction bits (unsigned Q0.11 coefficient)
//   OUT_W      : signed output sample width
// ---------------------------------------------------------------------------
package fir_acc_pkg;

  localparam int PROD_W     = 28;
  localparam int MAX_TAPS   = 64;
  localparam int TAP_CNT_W  = $clog2(MAX_TAPS);
  localparam int ACC_W      = PROD_W + TAP_CNT_W;
  localparam int FRAC_SHIFT = 11;
  localparam int OUT_W      = 16;

  // Saturation limits of the signed output sample.
  localparam logic [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
  localparam logic [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    ROUND = 2'd1,
    OUT   = 2'd2
  } state_e;

  // Sign-extend one multiplier product to accumulator width.
  function automatic logic signed [ACC_W-1:0] sext_prod(input logic [PROD_W-1:0] p);
    return ACC_W'(signed'(p));
  endfunction

endpackage : fir_acc_pkg

// File: rtl/fir_round_sat.sv
// ---------------------------------------------------------------------------
// fir_round_sat
//   Purely combinational rounding, shift and saturation of the accumulated
//   tap sum down to one signed output sample.
//
//   Configuration macro: FIR_ACC_CONVERGENT_ROUND_EN
//     undefined : round-half-up
//     defined   : round-half-to-even (exact ties go to the even integer)
//
//   Ports:
//     acc_i  in  ACC_W  signed accumulator value
//     out_o  out OUT_W  rounded, shifted, saturated sample
//     sat_o  out 1      the rounded value was outside the OUT_W range
// ---------------------------------------------------------------------------
module fir_round_sat
  import fir_acc_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc_i,
  output logic signed [OUT_W-1:0] out_o,
  output logic                    sat_o
);

  // One extra bit so adding the half-LSB bias can never overflow.
  localparam int SUM_W = ACC_W + 1;
  localparam int R_W   = SUM_W - FRAC_SHIFT;

  localparam logic signed [SUM_W-1:0] HALF  = SUM_W'(1) << (FRAC_SHIFT - 1);
  localparam logic signed [R_W-1:0]   R_MAX = {{(R_W-OUT_W){1'b0}}, OUT_MAX};
  localparam logic signed [R_W-1:0]   R_MIN = {{(R_W-OUT_W){1'b1}}, OUT_MIN};

  logic signed [SUM_W-1:0] biased;
  logic signed [R_W-1:0]   r_half_up;
  logic signed [R_W-1:0]   r;

  assign biased    = {acc_i[ACC_W-1], acc_i} + HALF;
  assign r_half_up = R_W'(biased >>> FRAC_SHIFT);

`ifdef FIR_ACC_CONVERGENT_ROUND_EN
  // On an exact tie, half-up gives floor+1; clearing the LSB then picks
  // whichever of floor / floor+1 is even.
  logic tie;
  assign tie = (acc_i[FRAC_SHIFT-1:0] == HALF[FRAC_SHIFT-1:0]);
  assign r   = tie ? {r_half_up[R_W-1:1], 1'b0} : r_half_up;
`else
  assign r = r_half_up;
`endif

  always_comb begin
    sat_o = 1'b0;
    out_o = r[OUT_W-1:0];
    if (r > R_MAX) begin
      out_o = OUT_MAX;
      sat_o = 1'b1;
    end else if (r < R_MIN) begin
      out_o = OUT_MIN;
      sat_o = 1'b1;
    end
  end

endmodule : fir_round_sat

// File: rtl/fir_mac_accumulator.sv
// ---------------------------------------------------------------------------
// fir_mac_accumulator
//   Sums the signed tap products of one FIR output sample, then rounds,
//   shifts and saturates the sum into a 16-bit sample for the next
//   filterbank stage. A sample ends on prod_tlast or, as a protection
//   against a missing tlast, after MAX_TAPS products (flagged on tap_err).
//
//   Configuration macro: FIR_ACC_CONVERGENT_ROUND_EN (inside fir_round_sat)
//     selects round-half-to-even instead of round-half-up.
//
//   Ports:
//     ap_clk       in   clock, rising edge
//     ap_rst       in   synchronous active-high reset
//     prod_tdata   in   PROD_W signed product
//     prod_tvalid  in   product valid
//     prod_tlast   in   last tap product of the sample
//     prod_tready  out  product accepted when high together with valid
//     out_tdata    out  OUT_W rounded, saturated sample
//     out_tvalid   out  sample valid, held until out_tready
//     out_tready   in   downstream accepts the sample
//     sat_flag     out  sticky: some output sample saturated
//     tap_err      out  sticky: a sample was force-ended without tlast
// ---------------------------------------------------------------------------
module fir_mac_accumulator
  import fir_acc_pkg::*;
(
  input  logic              ap_clk,
  input  logic              ap_rst,
  input  logic [PROD_W-1:0] prod_tdata,
  input  logic              prod_tvalid,
  input  logic              prod_tlast,
  output logic              prod_tready,
  output logic [OUT_W-1:0]  out_tdata,
  output logic              out_tvalid,
  input  logic              out_tready,
  output logic              sat_flag,
  output logic              tap_err
);

  state_e                  state_q;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic [TAP_CNT_W-1:0]    tap_cnt_q;
  logic                    first_q;
  logic [OUT_W-1:0]        out_tdata_q;
  logic                    out_tvalid_q;
  logic                    sat_flag_q;
  logic                    tap_err_q;

  logic                    prod_fire;
  logic                    forced_end;
  logic                    end_of_sample;
  logic signed [OUT_W-1:0] rnd_data;
  logic                    rnd_sat;

  // Ready is held low during reset so nothing is consumed while the
  // datapath is being cleared.
  assign prod_tready   = (state_q == ACCUM) && !ap_rst;
  assign prod_fire     = prod_tvalid && prod_tready;
  assign forced_end    = (tap_cnt_q == TAP_CNT_W'(MAX_TAPS - 1));
  assign end_of_sample = prod_tlast || forced_end;

  // The first product of a sample replaces the previous sum instead of
  // adding to it, so acc_q can keep the finished sum for ROUND.
  always_comb begin
    acc_d = (first_q ? '0 : acc_q) + sext_prod(prod_tdata);
  end

  fir_round_sat u_round_sat (
    .acc_i (acc_q),
    .out_o (rnd_data),
    .sat_o (rnd_sat)
  );

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_q      <= ACCUM;
      acc_q        <= '0;
      tap_cnt_q    <= '0;
      first_q      <= 1'b1;
      out_tdata_q  <= '0;
      out_tvalid_q <= 1'b0;
      sat_flag_q   <= 1'b0;
      tap_err_q    <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          if (prod_fire) begin
            acc_q     <= acc_d;
            first_q   <= 1'b0;
            tap_cnt_q <= tap_cnt_q + 1'b1;
            if (end_of_sample) begin
              state_q   <= ROUND;
              first_q   <= 1'b1;
              tap_cnt_q <= '0;
              if (!prod_tlast) begin
                tap_err_q <= 1'b1;
              end
            end
          end
        end

        ROUND: begin
          out_tdata_q  <= rnd_data;
          out_tvalid_q <= 1'b1;
          if (rnd_sat) begin
            sat_flag_q <= 1'b1;
          end
          state_q <= OUT;
        end

        OUT: begin
          if (out_tready) begin
            out_tvalid_q <= 1'b0;
            state_q      <= ACCUM;
          end
        end

        default: begin
          state_q <= ACCUM;
        end
      endcase
    end
  end

  assign out_tdata  = out_tdata_q;
  assign out_tvalid = out_tvalid_q;
  assign sat_flag   = sat_flag_q;
  assign tap_err    = tap_err_q;

endmodule : fir_mac_accumulator

// File: tb/tb_fir_mac_accumulator.sv
// ---------------------------------------------------------------------------
// tb_fir_mac_accumulator
//   Randomised and directed stimulus against a behavioural model that sums
//   products as plain integers and rounds with integer floor division.
//   Expected samples are queued at acceptance of the closing beat; a
//   separate monitor compares each output handshake against the queue.
// ---------------------------------------------------------------------------
module tb_fir_mac_accumulator;
  import fir_acc_pkg::*;

  logic              ap_clk = 1'b0;
  logic              ap_rst = 1'b1;
  logic [PROD_W-1:0] prod_tdata = '0;
  logic              prod_tvalid = 1'b0;
  logic              prod_tlast = 1'b0;
  logic              prod_tready;
  logic [OUT_W-1:0]  out_tdata;
  logic              out_tvalid;
  logic              out_tready = 1'b1;
  logic              sat_flag;
  logic              tap_err;

  fir_mac_accumulator dut (
    .ap_clk      (ap_clk),
    .ap_rst      (ap_rst),
    .prod_tdata  (prod_tdata),
    .prod_tvalid (prod_tvalid),
    .prod_tlast  (prod_tlast),
    .prod_tready (prod_tready),
    .out_tdata   (out_tdata),
    .out_tvalid  (out_tvalid),
    .out_tready  (out_tready),
    .sat_flag    (sat_flag),
    .tap_err     (tap_err)
  );

  always #5 ap_clk = ~ap_clk;

  typedef struct {
    longint data;
    bit     sat;
    bit     err;
    longint acc_cyc;
  } exp_t;

  exp_t   sb_q[$];
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  longint cur_sum = 0;
  int     cur_taps = 0;
  bit     sat_sticky = 0;
  bit     err_sticky = 0;
  int     stall_left = 0;
  bit     rand_ready = 0;
  int     sample_no = 0;

  always @(posedge ap_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic longint floor_div(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  // Reference: sum / 2048 rounded to nearest, ties per rounding mode,
  // then clipped to the signed 16-bit range.
  task automatic model_round(input longint sum, output longint val, output bit sat);
    longint fl, frac, r;
    fl   = floor_div(sum, 2048);
    frac = sum - fl * 2048;
    if (frac > 1024)      r = fl + 1;
    else if (frac < 1024) r = fl;
    else begin
`ifdef FIR_ACC_CONVERGENT_ROUND_EN
      r = ((fl % 2) == 0) ? fl : fl + 1;
`else
      r = fl + 1;
`endif
    end
    sat = 0;
    val = r;
    if (r > 32767)       begin val = 32767;  sat = 1; end
    else if (r < -32768) begin val = -32768; sat = 1; end
  endtask

  task automatic model_accept(input longint d, input bit last);
    longint v;
    bit     s;
    exp_t   e;
    cur_sum  += d;
    cur_taps++;
    if (last || cur_taps == 64) begin
      model_round(cur_sum, v, s);
      if (s)     sat_sticky = 1;
      if (!last) err_sticky = 1;
      e.data    = v;
      e.sat     = sat_sticky;
      e.err     = err_sticky;
      e.acc_cyc = cyc;
      sb_q.push_back(e);
      cur_sum  = 0;
      cur_taps = 0;
    end
  endtask

  // Called at a falling edge; the beat is taken on the next rising edge
  // when prod_tready is high.
  task automatic send_beat(input logic [PROD_W-1:0] data, input bit last);
    int w;
    prod_tdata  = data;
    prod_tlast  = last;
    prod_tvalid = 1'b1;
    w = 0;
    while (!prod_tready && w < 2000) begin
      @(negedge ap_clk);
      w++;
    end
    if (!prod_tready) begin
      check("beat_accept_timeout", 0, 1);
    end else begin
      model_accept(longint'(signed'(data)), last);
      @(negedge ap_clk);
    end
    prod_tvalid = 1'b0;
    prod_tlast  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge ap_clk);
  endtask

  task automatic wait_drained();
    int w;
    w = 0;
    while ((sb_q.size() != 0 || out_tvalid) && w < 3000) begin
      @(negedge ap_clk);
      w++;
    end
    check("drain_timeout", (sb_q.size() == 0 && !out_tvalid) ? 1 : 0, 1);
  endtask

  // Downstream ready: a directed stall, random back-pressure, or always on.
  initial begin
    forever begin
      @(posedge ap_clk);
      #1;
      if (stall_left > 0) begin
        out_tready = 1'b0;
        if (out_tvalid) stall_left--;
      end else begin
        out_tready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Monitor / scoreboard
  logic             prev_valid = 1'b0;
  logic             prev_ready = 1'b0;
  logic [OUT_W-1:0] prev_data  = '0;

  initial begin
    exp_t e;
    forever begin
      @(negedge ap_clk);
      if (ap_rst) begin
        prev_valid = 1'b0;
      end else begin
        if (prev_valid && !prev_ready) begin
          check("hold_valid", out_tvalid, 1);
          check("hold_data", out_tdata, prev_data);
        end
        if (out_tvalid) begin
          check("ready_low_while_out", prod_tready, 0);
        end
        if (out_tvalid && !prev_valid) begin
          if (sb_q.size() == 0) check("unexpected_output", 1, 0);
          else                  check("latency", cyc, sb_q[0].acc_cyc + 2);
        end
        if (out_tvalid && out_tready && sb_q.size() != 0) begin
          e = sb_q.pop_front();
          sample_no++;
          $display("sample %0d: out=%0d exp=%0d sat_flag=%0b tap_err=%0b",
                   sample_no, $signed(out_tdata), e.data, sat_flag, tap_err);
          check("out_tdata", $signed(out_tdata), e.data);
          check("sat_flag", sat_flag, e.sat);
          check("tap_err", tap_err, e.err);
        end
        prev_valid = out_tvalid;
        prev_ready = out_tready;
        prev_data  = out_tdata;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [PROD_W-1:0] d;
    int taps, mode;

    // Reset state
    repeat (3) @(negedge ap_clk);
    check("rst_prod_tready", prod_tready, 0);
    check("rst_out_tvalid", out_tvalid, 0);
    check("rst_out_tdata", out_tdata, 0);
    check("rst_sat_flag", sat_flag, 0);
    check("rst_tap_err", tap_err, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("post_rst_prod_tready", prod_tready, 1);

    // Rounding ties and plain sums
    send_beat(PROD_W'(1024), 1);
    idle(4);
    send_beat(PROD_W'(1024), 0);
    send_beat(PROD_W'(2048), 1);
    send_beat(PROD_W'(-3072), 1);

    // Saturation both ways
    for (int i = 0; i < 4; i++) send_beat(PROD_W'(67108864), i == 3);
    for (int i = 0; i < 4; i++) send_beat(PROD_W'(-67108864), i == 3);
    wait_drained();

    // Downstream stall, next sample must start from zero
    stall_left = 5;
    send_beat(PROD_W'(2048), 1);
    send_beat(PROD_W'(4096), 0);
    send_beat(PROD_W'(4096), 1);
    wait_drained();

    // Missing tlast: forced end after 64 beats, then a normal sample
    for (int i = 0; i < 64; i++) send_beat(PROD_W'(2048), 0);
    send_beat(PROD_W'(6144), 1);
    wait_drained();

    // Reset in the middle of a sample
    for (int i = 0; i < 3; i++) send_beat(PROD_W'(2048), 0);
    ap_rst = 1'b1;
    sb_q.delete();
    cur_sum = 0; cur_taps = 0; sat_sticky = 0; err_sticky = 0;
    @(negedge ap_clk);
    check("mid_rst_prod_tready", prod_tready, 0);
    check("mid_rst_out_tvalid", out_tvalid, 0);
    check("mid_rst_out_tdata", out_tdata, 0);
    check("mid_rst_sat_flag", sat_flag, 0);
    check("mid_rst_tap_err", tap_err, 0);
    ap_rst = 1'b0;
    @(negedge ap_clk);
    check("mid_rst_release_ready", prod_tready, 1);
    for (int i = 0; i < 5; i++) send_beat(PROD_W'(2048), i == 4);
    wait_drained();

    // Random samples with random back-pressure and gaps
    rand_ready = 1;
    for (int s = 0; s < 150; s++) begin
      taps = $urandom_range(1, 70);
      mode = $urandom_range(0, 2);
      for (int i = 0; i < taps; i++) begin
        case (mode)
          0:       d = PROD_W'($urandom);
          1:       d = PROD_W'(int'($urandom_range(0, 32767)) - 16384);
          default: d = PROD_W'(int'($urandom_range(0, 2097151)) - 1048576);
        endcase
        send_beat(d, i == taps - 1);
        if ($urandom_range(0, 7) == 0) idle($urandom_range(1, 3));
      end
    end
    wait_drained();
    rand_ready = 0;
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_fir_mac_accumulator

// File: doc/fir_mac_accumulator.md
Name: fir_mac_accumulator

Overview:
- Downstream stage of the filter's 16s x 12ns -> 28-bit coefficient multiplier.
- Consumes one signed product per beat over a valid/ready stream. Sums all tap products of one output sample; the last tap is marked by prod_tlast.
- Rounds, shifts and saturates the sum to a 16-bit sample, then presents it on an output stream to the next filterbank stage (decimator/adder tree).

Parameters:
- PROD_W, 28, signed product width from the multiplier
- MAX_TAPS, 64, maximum products per sample; accumulator guard bits = clog2(MAX_TAPS)
- ACC_W, PROD_W+clog2(MAX_TAPS) = 34, accumulator width
- FRAC_SHIFT, 11, right shift that removes the coefficient fraction bits (unsigned Q0.11 coefficient)
- OUT_W, 16, signed output sample width

Ports:
- ap_clk  in  1  clock; all logic on rising edge
- ap_rst  in  1  synchronous, active-high reset
- prod_tdata  in  PROD_W  signed product
- prod_tvalid  in  1  product valid
- prod_tlast  in  1  marks last tap product of the sample
- prod_tready  out  1  accumulator can accept a product
- out_tdata  out  OUT_W  rounded, saturated sample
- out_tvalid  out  1  sample valid
- out_tready  in  1  downstream accepts the sample
- sat_flag  out  1  sticky: at least one output saturated
- tap_err  out  1  sticky: MAX_TAPS products arrived without tlast

Behaviour:
- Reset values:
  - state = ACCUM; acc = 0; tap_cnt = 0; first = 1.
  - prod_tready = 0 during reset, then 1.
  - out_tvalid = 0; out_tdata = 0; sat_flag = 0; tap_err = 0.
- Reset mid-operation discards the partial sum and any pending output. No beat is emitted.
- States:
  - ACCUM: prod_tready = 1. A beat is accepted when prod_tvalid && prod_tready.
    - acc <= (first ? 0 : acc) + sign_extend(prod_tdata, ACC_W).
    - first <= 0.
    - tap_cnt <= tap_cnt + 1.
    - On tlast, or when tap_cnt == MAX_TAPS-1 (forced end): go to ROUND, set first = 1, clear tap_cnt.
    - A forced end without tlast also sets tap_err.
  - ROUND: prod_tready = 0. Compute the rounded result, saturate it, and register it into out_tdata. Set out_tvalid = 1 and go to OUT.
  - OUT: prod_tready = 0. Hold out_tdata and out_tvalid until out_tready = 1. On the handshake, clear out_tvalid and go to ACCUM.
- Latency: tlast is accepted in cycle N; out_tvalid rises in cycle N+2.
- Throughput:
  - One product per cycle while in ACCUM.
  - Minimum 2 dead cycles between samples (ROUND, OUT with out_tready = 1).
- Rounding (default): round-half-up.
  - r = (acc + 2^(FRAC_SHIFT-1)) >>> FRAC_SHIFT, computed in ACC_W+1 bits so the addition cannot overflow.
- Saturation:
  - If r > 2^(OUT_W-1)-1, out = 32767. If r < -2^(OUT_W-1), out = -32768.
  - Either case sets sat_flag.
  - Otherwise out = r[OUT_W-1:0].
- Accumulator never wraps: ACC_W covers MAX_TAPS full-scale products.
- out_tdata and out_tvalid must remain stable while out_tvalid=1 and out_tready=0.
- Products presented while prod_tready = 0 are not consumed; the upstream stream holds them.
- sat_flag and tap_err are cleared only by ap_rst.

Optional Feature:
- FIR_ACC_CONVERGENT_ROUND_EN defined: round-half-to-even.
  - Exact ties (fraction bits == 2^(FRAC_SHIFT-1)) round to the even integer.
  - All other values behave as default.
- Not defined: round-half-up as above. No extra logic.

Decomposition:
- Package fir_acc_pkg holds:
  - default widths (PROD_W, ACC_W, OUT_W, FRAC_SHIFT, MAX_TAPS)
  - state enum type {ACCUM, ROUND, OUT}
  - OUT_MAX/OUT_MIN constants
- One sub-module, fir_round_sat. It is purely combinational: ACC_W in -> OUT_W out plus a sat bit, and contains the rounding-mode macro. The FSM, accumulator and counters stay in the top module.

Test Plan:
- Single beat 1024 with tlast (0.5) -> out_tdata = 1 default; 0 with FIR_ACC_CONVERGENT_ROUND_EN. out_tvalid 2 cycles after acceptance.
- Beats 1024, 2048 with tlast on the second (sum 3072 = 1.5) -> out = 2 in both modes. Beat -3072 with tlast -> out = -1 default; -2 convergent.
- 4 beats of 67108864 (sum 2^28) -> out = 32767, sat_flag=1. 4 beats of -67108864 -> out = -32768.
- out_tready held 0 for 5 cycles after out_tvalid -> out_tdata stable, prod_tready = 0, no products consumed. Release -> next sample accumulates from 0.
- 64 beats of 2048 without tlast -> forced end after beat 64, out = 64, tap_err=1. The following sample is unaffected.
- ap_rst asserted after 3 of 5 beats -> outputs return to reset values. The next full 5-beat sample of 2048 each gives out = 5.
